alu: RTL and testbench

- 4-bit-operand, 8-bit-result arithmetic/logic unit for the CPU datapath.
- Selects one of 16 operations by a 4-bit opcode and registers the result.
- Result is valid one clock after operands and opcode are applied.
- Sits between the register file / operand muxes and the accumulator write-back.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_datapath.sv | 51 +++++
 rtl/alu.sv | 36 +++
 tb/tb_alu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcode encoding and special-case constants for the datapath ALU.
package alu_pkg;

   localparam int OPW  = 4;
   localparam int RESW = 8;

   // Quotient reported when dividing by zero.
   localparam logic [RESW-1:0] DIV0_Q = 8'hFF;

   typedef enum logic [OPW-1:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_MUL  = 4'h2,
      OP_DIV  = 4'h3,
      OP_MOD  = 4'h4,
      OP_AND  = 4'h5,
      OP_OR   = 4'h6,
      OP_XOR  = 4'h7,
      OP_NAND = 4'h8,
      OP_NOT  = 4'h9,
      OP_SHL  = 4'hA,
      OP_SHR  = 4'hB,
      OP_ROL  = 4'hC,
      OP_ROR  = 4'hD,
      OP_CMP  = 4'hE,
      OP_CLR  = 4'hF
   } opcode_t;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU function: result f and its zero term for one opcode/operand set.
module alu_datapath
   import alu_pkg::*;
(
   input  logic [OPW-1:0]  a,
   input  logic [OPW-1:0]  b,
   input  logic [OPW-1:0]  op_code,
   output logic [RESW-1:0] f,
   output logic            f_zero
);

   logic [RESW-1:0] a8;
   logic [RESW-1:0] b8;
   logic [RESW-1:0] rol_w;
   logic [RESW-1:0] ror_w;
   opcode_t         op;

   assign a8 = {4'b0, a};
   assign b8 = {4'b0, b};
   assign op = opcode_t'(op_code);

   // Rotations within 4 bits: shift the nibble doubled, then keep one nibble.
   assign rol_w = {a, a} << b[1:0];
   assign ror_w = {a, a} >> b[1:0];

   always_comb begin
      f = '0;
      case (op)
         OP_ADD:  f = a8 + b8;
         OP_SUB:  f = a8 - b8;
         OP_MUL:  f = a8 * b8;
         OP_DIV:  f = (b == 4'd0) ? DIV0_Q : a8 / b8;
         OP_MOD:  f = (b == 4'd0) ? a8 : a8 % b8;
         OP_AND:  f = {4'b0, a & b};
         OP_OR:   f = {4'b0, a | b};
         OP_XOR:  f = {4'b0, a ^ b};
         OP_NAND: f = {4'b0, ~(a & b)};
         OP_NOT:  f = {4'b0, ~a};
         OP_SHL:  f = (b >= 4'd8) ? '0 : (a8 << b);
         OP_SHR:  f = {4'b0, a >> b};
         OP_ROL:  f = {4'b0, rol_w[7:4]};
         OP_ROR:  f = {4'b0, ror_w[3:0]};
         OP_CMP:  f = {5'b0, a > b, a == b, a < b};
         OP_CLR:  f = '0;
         default: f = '0;
      endcase
   end

   assign f_zero = (f == '0);

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency result and zero flag with asynchronous active-high reset.
module alu
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [OPW-1:0]  datain1,
   input  logic [OPW-1:0]  datain2,
   input  logic [OPW-1:0]  op_code,
   output logic [RESW-1:0] out,
   output logic            zero
);

   logic [RESW-1:0] f;
   logic            f_zero;

   alu_datapath u_datapath (
      .a       (datain1),
      .b       (datain2),
      .op_code (op_code),
      .f       (f),
      .f_zero  (f_zero)
   );

   // Reset state reports a cleared result, so the flag comes up set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out  <= '0;
         zero <= 1'b1;
      end else begin
         out  <= f;
         zero <= f_zero;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected {zero,out} pushed at drive time, popped after the edge.
module tb_alu;

   logic       clk;
   logic       reset;
   logic [3:0] datain1;
   logic [3:0] datain2;
   logic [3:0] op_code;
   logic [7:0] out;
   logic       zero;

   int checks;
   int failures;

   logic [8:0] sb[$];

   alu dut (
      .clk     (clk),
      .reset   (reset),
      .datain1 (datain1),
      .datain2 (datain2),
      .op_code (op_code),
      .out     (out),
      .zero    (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] model(input int a, input int b, input int op);
      int r;
      int s;
      s = b & 3;
      case (op)
         0:  r = a + b;
         1:  r = (a - b) & 255;
         2:  r = a * b;
         3:  r = (b == 0) ? 255 : a / b;
         4:  r = (b == 0) ? a : a % b;
         5:  r = a & b;
         6:  r = a | b;
         7:  r = a ^ b;
         8:  r = (~(a & b)) & 15;
         9:  r = (~a) & 15;
         10: r = (b >= 8) ? 0 : ((a << b) & 255);
         11: r = a >> b;
         12: r = ((a << s) | (a >> (4 - s))) & 15;
         13: r = ((a >> s) | (a << (4 - s))) & 15;
         14: r = ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a < b) ? 1 : 0);
         default: r = 0;
      endcase
      return r[7:0];
   endfunction

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [7:0] exp_out);
      @(negedge clk);
      datain1 = a;
      datain2 = b;
      op_code = op;
      sb.push_back({(exp_out == 8'h00), exp_out});
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      datain1 = 4'd0;
      datain2 = 4'd0;
      op_code = 4'hF;
      #1;
      checks++;
      if (out !== 8'h00) begin
         failures++;
         $display("FAIL reset_out got=%h exp=00", out);
      end
      checks++;
      if (zero !== 1'b1) begin
         failures++;
         $display("FAIL reset_zero got=%b exp=1", zero);
      end
      @(negedge clk);
      reset = 1'b0;
      drive(4'd0, 4'd0, 4'hF, 8'h00);
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0 || {zero, out} !== sb.pop_front()) begin
         failures++;
         $display("FAIL reset_first_load got=%b_%h exp=1_00", zero, out);
      end
   endtask

   task automatic test_directed;
      logic [3:0] ta[17] = '{4'd3, 4'd3, 4'd3, 4'd15, 4'd15, 4'd3, 4'd9, 4'd9,
                             4'd9, 4'd9, 4'd15, 4'd15, 4'd2, 4'd7, 4'd7, 4'd4, 4'd5};
      logic [3:0] tb_[17] = '{4'd2, 4'd2, 4'd2, 4'd15, 4'd15, 4'd5, 4'd0, 4'd0,
                              4'd1, 4'd1, 4'd4, 4'd8, 4'd7, 4'd7, 4'd2, 4'd3, 4'd7};
      logic [3:0] top[17] = '{4'h3, 4'h4, 4'h5, 4'h0, 4'h2, 4'h1, 4'h3, 4'h4,
                              4'hC, 4'hD, 4'hA, 4'hA, 4'hE, 4'hE, 4'hE, 4'hB, 4'hF};
      logic [7:0] tex[17] = '{8'h01, 8'h01, 8'h02, 8'd30, 8'd225, 8'hFE, 8'hFF, 8'h09,
                              8'h03, 8'h0C, 8'hF0, 8'h00, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00};
      logic [8:0] exp;
      for (int i = 0; i < 17; i++) begin
         drive(ta[i], tb_[i], top[i], tex[i]);
         @(posedge clk);
         #1;
         checks++;
         exp = (sb.size() != 0) ? sb.pop_front() : 9'h1FF;
         if ({zero, out} !== exp) begin
            failures++;
            $display("FAIL directed_%0d op=%h a=%0d b=%0d got=%b_%h exp=%b_%h",
                     i, top[i], ta[i], tb_[i], zero, out, exp[8], exp[7:0]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [8:0] exp;
      for (int v = 0; v < 4096; v++) begin
         drive(v[3:0], v[7:4], v[11:8], model(v & 15, (v >> 4) & 15, (v >> 8) & 15));
         @(posedge clk);
         #1;
         checks++;
         exp = (sb.size() != 0) ? sb.pop_front() : 9'h1FF;
         if ({zero, out} !== exp) begin
            failures++;
            $display("FAIL sweep op=%h a=%0d b=%0d got=%b_%h exp=%b_%h",
                     v[11:8], v[3:0], v[7:4], zero, out, exp[8], exp[7:0]);
         end
      end
   endtask

   task automatic test_async_reset;
      logic [8:0] exp;
      drive(4'd5, 4'd6, 4'h0, 8'd11);
      @(posedge clk);
      #1;
      checks++;
      exp = (sb.size() != 0) ? sb.pop_front() : 9'h1FF;
      if ({zero, out} !== exp) begin
         failures++;
         $display("FAIL midreset_pre got=%b_%h exp=%b_%h", zero, out, exp[8], exp[7:0]);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({zero, out} !== 9'h100) begin
         failures++;
         $display("FAIL midreset_async got=%b_%h exp=1_00", zero, out);
      end
      #1 reset = 1'b0;
      sb.push_back({1'b0, 8'd11});
      @(posedge clk);
      #1;
      checks++;
      exp = (sb.size() != 0) ? sb.pop_front() : 9'h1FF;
      if ({zero, out} !== exp) begin
         failures++;
         $display("FAIL midreset_reload got=%b_%h exp=%b_%h", zero, out, exp[8], exp[7:0]);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
